// File: rtl/pio_clkdiv_frac.sv
// Multi-channel fractional clock-enable generator for the PIO state machines.
// Each channel emits a one-cycle penable strobe every INT(+1) enabled cycles, dithered by a FRAC accumulator.
module pio_clkdiv_frac #(
    parameter int NUM_CH = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*INT_W-1:0]    div_int,
    input  logic [NUM_CH*FRAC_W-1:0]   div_frac,
    input  logic [NUM_CH-1:0]          enable,
    input  logic [NUM_CH-1:0]          restart,
    output logic [NUM_CH-1:0]          penable,
    output logic [NUM_CH-1:0]          pclk
);

    localparam logic [INT_W:0] CTR_ONE = {{INT_W{1'b0}}, 1'b1};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [INT_W:0]    ctr;
        logic [FRAC_W-1:0] acc;
        logic              pen_q;
        logic              pclk_q;
        logic [INT_W-1:0]  d_int;
        logic [FRAC_W-1:0] d_frac;
        logic [INT_W:0]    int_eff;
        logic [FRAC_W:0]   frac_sum;
        logic [INT_W:0]    reload;

        assign d_int  = div_int[c*INT_W +: INT_W];
        assign d_frac = div_frac[c*FRAC_W +: FRAC_W];

        // A zero divisor stands for 2^INT_W; the reload adds the accumulator carry for long intervals.
        assign int_eff  = (d_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, d_int};
        assign frac_sum = {1'b0, acc} + {1'b0, d_frac};
        assign reload   = int_eff + {{INT_W{1'b0}}, frac_sum[FRAC_W]};

        always_ff @(posedge clk) begin
            if (reset || restart[c]) begin
                ctr    <= CTR_ONE;
                acc    <= '0;
                pen_q  <= 1'b0;
                pclk_q <= 1'b0;
            end else if (enable[c]) begin
                if (ctr == CTR_ONE) begin
                    pen_q  <= 1'b1;
                    pclk_q <= ~pclk_q;
                    acc    <= frac_sum[FRAC_W-1:0];
                    ctr    <= reload;
                end else begin
                    pen_q <= 1'b0;
                    ctr   <= ctr - CTR_ONE;
                end
            end else begin
                pen_q <= 1'b0;
            end
        end

        assign penable[c] = pen_q;
        assign pclk[c]    = pclk_q;
    end

endmodule

// File: tb/tb_pio_clkdiv_frac.sv
// Directed self-checking bench for pio_clkdiv_frac with hand-computed strobe positions.
// INT_W is reduced to 4 so the divide-by-2^INT_W case stays short.
module tb_pio_clkdiv_frac;

    localparam int NUM_CH = 4;
    localparam int INT_W  = 4;
    localparam int FRAC_W = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH*INT_W-1:0]  div_int;
    logic [NUM_CH*FRAC_W-1:0] div_frac;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH-1:0]        restart;
    logic [NUM_CH-1:0]        penable;
    logic [NUM_CH-1:0]        pclk;

    int total = 0;
    int bad   = 0;
    logic [3:0] pen_hist[$];
    logic [3:0] pclk_hist[$];
    int se[$];

    always #5 clk = ~clk;

    pio_clkdiv_frac #(.NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_int  (div_int),
        .div_frac (div_frac),
        .enable   (enable),
        .restart  (restart),
        .penable  (penable),
        .pclk     (pclk)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [3:0] rs);
        enable  = en;
        restart = rs;
        @(posedge clk);
        #1;
        pen_hist.push_back(penable);
        pclk_hist.push_back(pclk);
    endtask

    task automatic setDiv(input int ch, input int di, input int df);
        div_int[ch*INT_W +: INT_W]    = di[INT_W-1:0];
        div_frac[ch*FRAC_W +: FRAC_W] = df[FRAC_W-1:0];
    endtask

    function automatic logic penAt(input int idx, input int ch);
        logic [3:0] v;
        v = pen_hist[idx];
        return v[ch];
    endfunction

    function automatic logic pclkAt(input int idx, input int ch);
        logic [3:0] v;
        v = pclk_hist[idx];
        return v[ch];
    endfunction

    // Edge numbers (1-based from the last history clear) at which channel ch strobed.
    task automatic gatherStrobes(input int ch);
        se.delete();
        for (int i = 0; i < pen_hist.size(); i++)
            if (penAt(i, ch)) se.push_back(i + 1);
    endtask

    // ch0 div 3, ch1 div 4, ch2 div 2 + 128/256, ch3 div 1, all starting from a cleared state.
    function automatic logic [3:0] expPen(input int e);
        logic [3:0] r;
        r[0] = ((e - 1) % 3 == 0);
        r[1] = ((e - 1) % 4 == 0);
        r[2] = ((e - 1) % 5 == 0) || ((e - 1) % 5 == 2);
        r[3] = 1'b1;
        return r;
    endfunction

    task automatic runMixed(input string name);
        logic [3:0] exp_p;
        logic [3:0] exp_c;
        exp_c = 4'b0;
        for (int e = 1; e <= 12; e++) begin
            applyStimulus(4'hF, 4'h0);
            exp_p = expPen(e);
            exp_c = exp_c ^ exp_p;
            checkOutput($sformatf("%s_pen_e%0d", name, e), penable, exp_p);
            checkOutput($sformatf("%s_pclk_e%0d", name, e), pclk, exp_c);
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = '0;
        restart  = '0;
        div_int  = '0;
        div_frac = '0;
        setDiv(0, 3, 0);
        setDiv(1, 4, 0);
        setDiv(2, 2, 128);
        setDiv(3, 1, 0);
        repeat (3) applyStimulus(4'h0, 4'h0);
        checkOutput("reset_pen", penable, 0);
        checkOutput("reset_pclk", pclk, 0);

        reset = 1'b0;
        runMixed("por");

        // Reset in the middle of a run must reproduce the power-on sequence.
        repeat (5) applyStimulus(4'hF, 4'h0);
        reset = 1'b1;
        applyStimulus(4'hF, 4'h0);
        checkOutput("midreset_pen", penable, 0);
        checkOutput("midreset_pclk", pclk, 0);
        reset = 1'b0;
        runMixed("rerun");

        setDiv(0, 2, 128);
        applyStimulus(4'h1, 4'h1);
        pen_hist.delete();
        repeat (1000) applyStimulus(4'h1, 4'h0);
        gatherStrobes(0);
        checkOutput("frac_count", se.size(), 400);
        checkOutput("frac_first", se[0], 1);
        checkOutput("frac_gap1", se[1] - se[0], 2);
        checkOutput("frac_gap2", se[2] - se[1], 3);
        checkOutput("frac_gap3", se[3] - se[2], 2);
        checkOutput("frac_gap4", se[4] - se[3], 3);

        setDiv(0, 1, 0);
        applyStimulus(4'h1, 4'h1);
        for (int e = 1; e <= 6; e++) begin
            applyStimulus(4'h1, 4'h0);
            checkOutput($sformatf("div1_pen_e%0d", e), penable[0], 1);
            checkOutput($sformatf("div1_pclk_e%0d", e), pclk[0], e % 2);
        end

        setDiv(0, 0, 0);
        applyStimulus(4'h1, 4'h1);
        pen_hist.delete();
        repeat (40) applyStimulus(4'h1, 4'h0);
        gatherStrobes(0);
        checkOutput("div0_count", se.size(), 3);
        checkOutput("div0_s1", se[1], 17);
        checkOutput("div0_s2", se[2], 33);

        // Pause for 7 cycles with ctr at 3: gap stretches from 5 to 12.
        setDiv(0, 5, 0);
        applyStimulus(4'h1, 4'h1);
        pen_hist.delete();
        pclk_hist.delete();
        repeat (3) applyStimulus(4'h1, 4'h0);
        repeat (7) applyStimulus(4'h0, 4'h0);
        repeat (5) applyStimulus(4'h1, 4'h0);
        gatherStrobes(0);
        checkOutput("pause_count", se.size(), 2);
        checkOutput("pause_gap", se[1] - se[0], 12);
        checkOutput("pause_pclk_hold", pclkAt(9, 0), 1);
        checkOutput("pause_pclk_after", pclkAt(12, 0), 0);

        applyStimulus(4'h1, 4'h1);
        pen_hist.delete();
        repeat (5) applyStimulus(4'h1, 4'h0);
        repeat (2) applyStimulus(4'h0, 4'h0);
        repeat (2) applyStimulus(4'h1, 4'h0);
        checkOutput("termpause_e6", penAt(5, 0), 0);
        checkOutput("termpause_e7", penAt(6, 0), 0);
        checkOutput("termpause_e8", penAt(7, 0), 1);
        checkOutput("termpause_e9", penAt(8, 0), 0);

        applyStimulus(4'h1, 4'h1);
        pen_hist.delete();
        repeat (3) applyStimulus(4'h1, 4'h0);
        setDiv(0, 2, 0);
        repeat (9) applyStimulus(4'h1, 4'h0);
        gatherStrobes(0);
        checkOutput("divchg_s1", se[1], 6);
        checkOutput("divchg_s2", se[2], 8);
        checkOutput("divchg_s3", se[3], 10);

        // Restart channel 1 alone at edge 7; channel 0 must keep its cadence.
        setDiv(0, 3, 0);
        setDiv(1, 4, 0);
        applyStimulus(4'h3, 4'h3);
        pen_hist.delete();
        for (int e = 1; e <= 17; e++) begin
            logic exp1;
            applyStimulus(4'h3, (e == 7) ? 4'h2 : 4'h0);
            if (e < 7)       exp1 = ((e - 1) % 4 == 0);
            else if (e == 7) exp1 = 1'b0;
            else             exp1 = ((e - 8) % 4 == 0);
            checkOutput($sformatf("rst1_ch0_e%0d", e), penable[0], ((e - 1) % 3 == 0));
            checkOutput($sformatf("rst1_ch1_e%0d", e), penable[1], exp1);
        end

        // Restart on a terminal edge clears acc, so the carry comes one strobe later.
        setDiv(2, 2, 128);
        applyStimulus(4'h4, 4'h4);
        pen_hist.delete();
        repeat (2) applyStimulus(4'h4, 4'h0);
        applyStimulus(4'h4, 4'h4);
        repeat (6) applyStimulus(4'h4, 4'h0);
        gatherStrobes(2);
        checkOutput("termrst_count", se.size(), 4);
        checkOutput("termrst_s1", se[1], 4);
        checkOutput("termrst_s2", se[2], 6);
        checkOutput("termrst_s3", se[3], 9);

        setDiv(2, 5, 0);
        setDiv(3, 2, 0);
        repeat (7) applyStimulus(4'hF, 4'h0);
        applyStimulus(4'hF, 4'hF);
        checkOutput("align_rst", penable, 0);
        applyStimulus(4'hF, 4'h0);
        checkOutput("align_e1", penable, 4'hF);
        applyStimulus(4'hF, 4'h0);
        checkOutput("align_e2", penable, 4'h0);
        applyStimulus(4'hF, 4'h0);
        checkOutput("align_e3", penable, 4'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_clkdiv_frac.md
# pio_clkdiv_frac

Multi-channel fractional clock-enable generator for the PIO block: one independent divider per state machine, each producing a single-cycle `penable` strobe at an average rate of f_clk / (INT + FRAC/2^FRAC_W) plus a toggling `pclk`. This block replaces the single-channel integer divider. It adds a per-channel fractional part (first-order accumulator dithering), run/pause gating, and a synchronous restart used by the CTRL register's CLKDIV_RESTART bits. It sits between the PIO register file (CLKDIVn, CTRL) and the state-machine cores.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent divider channels
- `INT_W`, 16, integer divisor width
- `FRAC_W`, 8, fractional divisor width

Ports:
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `div_int`  in  NUM_CH*INT_W  integer divisor per channel; channel c at [c*INT_W +: INT_W]; 0 means 2^INT_W
- `div_frac`  in  NUM_CH*FRAC_W  fractional divisor per channel; channel c at [c*FRAC_W +: FRAC_W]
- `enable`  in  NUM_CH  run enable per channel (level)
- `restart`  in  NUM_CH  per-channel restart strobe (level-sampled each cycle)
- `penable`  out  NUM_CH  one-clk-wide advance strobe per channel, registered
- `pclk`  out  NUM_CH  toggles on every `penable` assertion, registered

## Operation
- Per-channel state: `ctr` (INT_W+1 bits), `acc` (FRAC_W bits), `penable` flop, `pclk` flop.
- Effective integer: `int_eff = (div_int == 0) ? 2^INT_W : div_int`, width INT_W+1.
- Priority per channel and edge: reset > restart > enable > hold.
- Reset: `ctr <= 1`, `acc <= 0`, `penable <= 0`, `pclk <= 0` on all channels.
- Restart (bit c high): same loads as reset, for channel c only. Takes priority over `enable`. Other channels are unaffected.
- Enable high, `ctr == 1` (terminal):
  - `penable <= 1`, `pclk <= ~pclk`
  - `{carry, acc} <= acc + div_frac` (FRAC_W+1-bit sum)
  - `ctr <= int_eff + carry`
- Enable high, `ctr > 1`: `penable <= 0`, `ctr <= ctr - 1`.
- Enable low: `penable <= 0`. `ctr`, `acc` and `pclk` hold, so a pause preserves phase and the dither sequence.
- Divisor sampling: `div_int` and `div_frac` are sampled only at the terminal edge. A change mid-interval takes effect on the next interval; the interval in progress is never truncated.
- Interval length is `int_eff` or `int_eff + 1` enabled cycles. The long/short pattern follows accumulator overflow, so the long-run average is exactly `int_eff + div_frac/2^FRAC_W`.
- `div_int = 1`, `div_frac = 0`: `penable` is constantly high while enabled, and `pclk` toggles every cycle.
- Max reload is 2^INT_W + 1, which fits in INT_W+1 bits; no overflow is possible.
- Channels share nothing but `clk` and `reset`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- After reset or restart with `enable` high, the first `penable` is asserted after the first enabled edge (latency 1 cycle). Subsequent strobes follow at reload intervals.
- `penable` width is exactly 1 cycle, except in the divide-by-1 case, where it is continuous.
- `enable` deasserted on the same edge `ctr == 1`: no strobe, and `ctr` stays at 1. The strobe fires on the first edge after `enable` returns high.
- `restart` asserted on a terminal edge: the strobe is suppressed and `acc` is cleared. The next enabled edge strobes.
- `reset` asserted mid-interval: all channel state clears on that edge. Outputs are 0 from the following cycle.

## Test plan
- Channel 0 at `div_int=3`, `div_frac=0`, `enable=1` after reset -> `penable` high on enabled edges 1, 4, 7, 10; `pclk` toggles at each strobe.
- `div_int=2`, `div_frac=128` -> strobe intervals 2, 3, 2, 3 repeating. Over 1000 enabled cycles, exactly 400 strobes.
- `div_int=1`, `div_frac=0` -> `penable` continuously 1 and `pclk` toggling every cycle. `div_int=0` with `INT_W=4` -> interval 16.
- `div_int=5`, drop `enable` for 7 cycles at `ctr=3` -> the strobe after resume arrives 2 enabled cycles later, and the total gap is 5+7 cycles. Changing `div_int` to 2 mid-interval -> the current interval stays 5 and the next is 2.
- Restart on channel 1 mid-interval (`div_int=4`) with channel 0 running at `div_int=3` -> channel 1 strobes on the edge after restart and then every 4 cycles. Channel 0's cadence is unchanged. Simultaneous restart of all channels aligns their strobes.
- Assert `reset` mid-run on all 4 channels -> the next cycle shows `penable=0` and `pclk=0`, and the strobe sequence restarts identically to after power-on reset.
